// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: the mul/div
//   sequencer state encoding and the default latencies and counter width.
//   No ports; imported by pipe_hazard_ctrl and pipe_hazard_ctrl_md_seq.
package pipe_hazard_ctrl_pkg;

  // Mul/div sequencer states. The encodings are fixed so that other
  // pipeline blocks can decode them.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 33;
  localparam int DEF_CNT_W   = 6;

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// pipe_hazard_ctrl_md_seq
//   Mul/div occupancy sequencer. It freezes the EX stage while a multiply
//   or divide runs, then presents a DONE cycle in which the result is valid.
//   Ports:
//     clk, rset      clock and synchronous active-high reset
//     ex_md_start    EX holds a mul/div (level)
//     ex_md_is_div   1 = divide, 0 = multiply
//     exc_flush      exception flush, aborts any operation
//     mem_stall      data-memory wait is freezing the pipeline
//     md_hold        EX must be held (a bubble goes into EX-MEM)
//     md_busy        sequencer is in RUN
//     md_done        result valid this cycle
module pipe_hazard_ctrl_md_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rset,
  input  logic ex_md_start,
  input  logic ex_md_is_div,
  input  logic exc_flush,
  input  logic mem_stall,
  output logic md_hold,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // The IDLE cycle in which the op is first seen already counts as a stall
  // cycle, so the counter is loaded with LAT-1 and the op reaches DONE after
  // exactly LAT frozen cycles. The counter keeps running during a memory
  // wait. DONE is left when EX-MEM loads; outside an exception, which is
  // handled first, that is exactly when there is no memory wait, so
  // mem_stall is used directly and there is no path back from the top's
  // enable logic.
  always_ff @(posedge clk) begin
    if (rset || exc_flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (ex_md_start && !mem_stall) begin
            state <= MD_RUN;
            cnt   <= ex_md_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_RUN: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= MD_DONE;
        end
        MD_DONE: begin
          if (!mem_stall) state <= MD_IDLE;
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // These outputs are combinational from the state and the inputs. They are
  // forced low during reset, and md_done is suppressed when an exception
  // flush discards the result.
  always_comb begin
    md_hold = !rset && ((state == MD_IDLE && ex_md_start) || state == MD_RUN);
    md_busy = !rset && (state == MD_RUN);
    md_done = !rset && !exc_flush && (state == MD_DONE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It resolves
//   exception flush, data-memory wait, mul/div hold, load-use and branch
//   redirect, in that priority order.
//   Ports:
//     clk, rset                      clock and synchronous active-high reset
//     id_load_use                    load-use hazard detected in ID
//     ex_md_start, ex_md_is_div      mul/div present in EX, and its kind
//     dmem_req, dmem_ack             data-memory request and completion
//     ex_redirect                    taken branch in EX (held until accepted)
//     exc_flush                      exception committed in MEM
//     pc_en, *_en                    stage register load enables
//     *_flush                        stage register loads a bubble
//     redirect_taken                 ex_redirect accepted this cycle
//     md_busy, md_done               mul/div sequencer status
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rset,
  input  logic id_load_use,
  input  logic ex_md_start,
  input  logic ex_md_is_div,
  input  logic dmem_req,
  input  logic dmem_ack,
  input  logic ex_redirect,
  input  logic exc_flush,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic mem_wb_en,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic ex_mem_flush,
  output logic mem_wb_flush,
  output logic redirect_taken,
  output logic md_busy,
  output logic md_done
);

  logic mem_stall;
  logic md_hold;

  assign mem_stall = dmem_req && !dmem_ack;

  pipe_hazard_ctrl_md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md_seq (
    .clk         (clk),
    .rset        (rset),
    .ex_md_start (ex_md_start),
    .ex_md_is_div(ex_md_is_div),
    .exc_flush   (exc_flush),
    .mem_stall   (mem_stall),
    .md_hold     (md_hold),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  // Priority mux. A stage that is flushed also has its enable set, so that
  // "load a bubble" always looks the same to the stage register. A redirect
  // is accepted only when nothing above it is stalling; otherwise the
  // source keeps holding it.
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    mem_wb_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    mem_wb_flush   = 1'b0;
    redirect_taken = 1'b0;
    if (rset) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (exc_flush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (md_hold) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (id_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush    = 1'b1;
      redirect_taken = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl: a table of single-cycle
//   priority vectors plus hand-written multi-cycle sequences for
//   mul, div under a memory wait, exception abort, redirect and reset.
module tb_pipe_hazard_ctrl;

  // Output vector order:
  // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush |
  //  redirect_taken, md_busy, md_done}
  localparam logic [11:0] V_ZERO = 12'b00000_0000_000;
  localparam logic [11:0] V_NONE = 12'b11111_0000_000;
  localparam logic [11:0] V_LU   = 12'b00111_0100_000;
  localparam logic [11:0] V_RD   = 12'b11111_1000_100;
  localparam logic [11:0] V_MS   = 12'b00001_0001_000;
  localparam logic [11:0] V_EXC  = 12'b11111_1111_000;
  localparam logic [11:0] V_XS   = 12'b00011_0010_000;
  localparam logic [11:0] B_BUSY = 12'b00000_0000_010;
  localparam logic [11:0] B_DONE = 12'b00000_0000_001;

  // Input vector order: {load_use, md_start, is_div, req, ack, redirect, exc}
  typedef struct {
    string       name;
    logic [6:0]  stim;
    logic [11:0] exp;
  } vec_t;

  logic clk;
  logic rset;
  logic id_load_use, ex_md_start, ex_md_is_div, dmem_req, dmem_ack;
  logic ex_redirect, exc_flush;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic redirect_taken, md_busy, md_done;
  logic [11:0] actual;

  int total;
  int bad;

  vec_t vecs[12];

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rset          (rset),
    .id_load_use   (id_load_use),
    .ex_md_start   (ex_md_start),
    .ex_md_is_div  (ex_md_is_div),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .ex_redirect   (ex_redirect),
    .exc_flush     (exc_flush),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_flush  (mem_wb_flush),
    .redirect_taken(redirect_taken),
    .md_busy       (md_busy),
    .md_done       (md_done)
  );

  assign actual = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                   redirect_taken, md_busy, md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] stim);
    {id_load_use, ex_md_start, ex_md_is_div, dmem_req, dmem_ack,
     ex_redirect, exc_flush} = stim;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] exp);
    total++;
    if (actual !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{"none",          7'b0000000, V_NONE};
    vecs[1]  = '{"load_use",      7'b1000000, V_LU};
    vecs[2]  = '{"redirect",      7'b0000010, V_RD};
    vecs[3]  = '{"lu_over_rd",    7'b1000010, V_LU};
    vecs[4]  = '{"mem_stall",     7'b0001000, V_MS};
    vecs[5]  = '{"ms_over_rd",    7'b0001010, V_MS};
    vecs[6]  = '{"ms_over_lu",    7'b1001000, V_MS};
    vecs[7]  = '{"exc_over_ms",   7'b0001001, V_EXC};
    vecs[8]  = '{"exc_over_rd",   7'b1000011, V_EXC};
    vecs[9]  = '{"req_acked",     7'b0001100, V_NONE};
    vecs[10] = '{"ms_over_md",    7'b0111000, V_MS};
    vecs[11] = '{"exc_over_md",   7'b0100001, V_EXC};

    // Reset with active inputs: everything must read zero.
    rset = 1'b1;
    applyStimulus(7'b0100010);
    stepCycle();
    checkOutput("reset", V_ZERO);
    stepCycle();
    rset = 1'b0;
    applyStimulus(7'b0000000);
    checkOutput("post_reset", V_NONE);

    // Single-cycle priority table; none of these starts the sequencer.
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      applyStimulus(vecs[i].stim);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Multiply: EX frozen cycles 0-3, done in cycle 4.
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      applyStimulus(7'b0100000);
      if (c == 0)     checkOutput("mul_c0", V_XS);
      else if (c < 4) checkOutput("mul_run", V_XS | B_BUSY);
      else            checkOutput("mul_done", V_NONE | B_DONE);
    end
    stepCycle();
    applyStimulus(7'b0000000);
    checkOutput("mul_after", V_NONE);

    // Divide with a memory wait in cycles 5-40: counter keeps running,
    // DONE at cycle 33 and held until the wait clears at cycle 41.
    for (int c = 0; c < 42; c++) begin
      stepCycle();
      applyStimulus((c >= 5 && c <= 40) ? 7'b0111000 : 7'b0110000);
      if (c == 0)       checkOutput("div_c0", V_XS);
      else if (c < 5)   checkOutput("div_run", V_XS | B_BUSY);
      else if (c <= 32) checkOutput("div_run_ms", V_MS | B_BUSY);
      else if (c <= 40) checkOutput("div_done_ms", V_MS | B_DONE);
      else              checkOutput("div_done", V_NONE | B_DONE);
    end
    stepCycle();
    applyStimulus(7'b0000000);
    checkOutput("div_after", V_NONE);

    // Exception in divide RUN with cnt=10 (cycle 23); md_done must stay low.
    for (int c = 0; c < 24; c++) begin
      stepCycle();
      applyStimulus((c == 23) ? 7'b0110001 : 7'b0110000);
      if (c == 0)       checkOutput("exc_div_c0", V_XS);
      else if (c < 23)  checkOutput("exc_div_run", V_XS | B_BUSY);
      else              checkOutput("exc_in_run", V_EXC | B_BUSY);
    end
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      applyStimulus(7'b0000000);
      checkOutput("exc_after", V_NONE);
    end

    // Load-use for one cycle, then free flow.
    stepCycle();
    applyStimulus(7'b1000000);
    checkOutput("lu_cycle", V_LU);
    stepCycle();
    applyStimulus(7'b0000000);
    checkOutput("lu_release", V_NONE);

    // Redirect held behind a load-use, accepted once it drops.
    stepCycle();
    applyStimulus(7'b1000010);
    checkOutput("rd_blocked", V_LU);
    stepCycle();
    applyStimulus(7'b0000010);
    checkOutput("rd_taken", V_RD);
    stepCycle();
    applyStimulus(7'b0000000);
    checkOutput("rd_after", V_NONE);

    // Reset in the middle of a multiply.
    stepCycle();
    applyStimulus(7'b0100000);
    checkOutput("rst_mul_c0", V_XS);
    stepCycle();
    applyStimulus(7'b0100000);
    checkOutput("rst_mul_c1", V_XS | B_BUSY);
    stepCycle();
    rset = 1'b1;
    applyStimulus(7'b0100000);
    checkOutput("rst_in_run", V_ZERO);
    stepCycle();
    rset = 1'b0;
    applyStimulus(7'b0000000);
    checkOutput("rst_release", V_NONE);
    stepCycle();
    applyStimulus(7'b0000000);
    checkOutput("rst_release2", V_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
